// File: rtl/param_reg_file.sv
// param_reg_file: flop-based 2R1W register file with registered reads,
// same-cycle write bypass and a sequential whole-array clear.
module param_reg_file #(
    parameter int ADDR_W   = 4,
    parameter int WIDTH    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ren1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              ren2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [WIDTH-1:0]  rdata1_q, rdata1_d;
    logic [WIDTH-1:0]  rdata2_q, rdata2_d;
    logic              clr_done_q, clr_done_d;
    logic              idle, wr_ok, zero1, zero2;

    // Read ports: bypass only applies to a write that will actually land.
    always_comb begin
        idle  = (state_q == IDLE);
        wr_ok = idle && wen && !((ZERO_REG != 0) && (waddr == '0));
        zero1 = (ZERO_REG != 0) && (raddr1 == '0);
        zero2 = (ZERO_REG != 0) && (raddr2 == '0);

        rdata1_d = rdata1_q;
        if (ren1) begin
            if (zero1) begin
                rdata1_d = '0;
            end else if (wr_ok && (raddr1 == waddr)) begin
                rdata1_d = wdata;
            end else begin
                rdata1_d = mem_q[raddr1];
            end
        end

        rdata2_d = rdata2_q;
        if (ren2) begin
            if (zero2) begin
                rdata2_d = '0;
            end else if (wr_ok && (raddr2 == waddr)) begin
                rdata2_d = wdata;
            end else begin
                rdata2_d = mem_q[raddr2];
            end
        end
    end

    always_comb begin
        mem_d      = mem_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    mem_d[waddr] = wdata;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            clr_done_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign rdata1   = rdata1_q;
    assign rdata2   = rdata2_q;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: directed table, clear/reset sequences and random
// traffic checked against a behavioural register-file model.
module tb_param_reg_file;
    localparam int AW = 4;
    localparam int W  = 16;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [W-1:0]  wdata = '0;
    logic          ren1 = 1'b0;
    logic [AW-1:0] raddr1 = '0;
    logic          ren2 = 1'b0;
    logic [AW-1:0] raddr2 = '0;
    logic          clr_req = 1'b0;
    logic [W-1:0]  rdata1, rdata2;
    logic          clr_busy, clr_done;

    int tests = 0;
    int fails = 0;

    param_reg_file #(.ADDR_W(AW), .WIDTH(W), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren1(ren1), .raddr1(raddr1), .ren2(ren2), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: clear is a count of remaining cycles plus a position.
    logic [W-1:0] m_mem [D];
    logic [W-1:0] m_rd1, m_rd2;
    int           m_left, m_pos;
    bit           m_done;

    function automatic void model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_rd1 = '0; m_rd2 = '0;
        m_left = 0; m_pos = 0; m_done = 0;
    endfunction

    function automatic logic [W-1:0] model_read(input logic [AW-1:0] a, input bit idle);
        if (a == 0) return '0;
        if (idle && wen && waddr != 0 && a == waddr) return wdata;
        return m_mem[a];
    endfunction

    function automatic void model_step();
        bit idle;
        idle = (m_left == 0);
        if (ren1) m_rd1 = model_read(raddr1, idle);
        if (ren2) m_rd2 = model_read(raddr2, idle);
        if (idle) begin
            m_done = 0;
            if (wen && waddr != 0) m_mem[waddr] = wdata;
            if (clr_req) begin
                m_left = D;
                m_pos  = 0;
            end
        end else begin
            m_mem[m_pos] = '0;
            m_pos++;
            m_left--;
            m_done = (m_left == 0);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " rdata1"}, 32'(rdata1), 32'(m_rd1));
        check({tag, " rdata2"}, 32'(rdata2), 32'(m_rd2));
        check({tag, " clr_busy"}, 32'(clr_busy), 32'(m_left != 0));
        check({tag, " clr_done"}, 32'(clr_done), 32'(m_done));
    endtask

    task automatic idle_inputs();
        wen = 0; ren1 = 0; ren2 = 0; clr_req = 0;
    endtask

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic          ren1;
        logic [AW-1:0] raddr1;
        logic          ren2;
        logic [AW-1:0] raddr2;
        logic [W-1:0]  e1;
        logic [W-1:0]  e2;
    } vec_t;

    function automatic vec_t mk(input logic we, input int wa, input int wd,
                                input logic r1, input int a1, input logic r2,
                                input int a2, input int e1, input int e2);
        vec_t v;
        v.wen = we; v.waddr = AW'(wa); v.wdata = W'(wd);
        v.ren1 = r1; v.raddr1 = AW'(a1); v.ren2 = r2; v.raddr2 = AW'(a2);
        v.e1 = W'(e1); v.e2 = W'(e2);
        return v;
    endfunction

    vec_t tbl [12];
    int   busy_cnt, done_cnt;

    initial begin
        tbl[0]  = mk(1, 5, 'hBEEF, 0, 0, 0, 0, 'h0000, 'h0000);
        tbl[1]  = mk(0, 0, 0,      1, 5, 0, 0, 'hBEEF, 'h0000);
        tbl[2]  = mk(1, 7, 'h1234, 0, 0, 1, 7, 'hBEEF, 'h1234);
        tbl[3]  = mk(1, 0, 'hFFFF, 0, 0, 0, 0, 'hBEEF, 'h1234);
        tbl[4]  = mk(0, 0, 0,      1, 0, 1, 0, 'h0000, 'h0000);
        tbl[5]  = mk(1, 3, 'hA5A5, 0, 0, 0, 0, 'h0000, 'h0000);
        tbl[6]  = mk(0, 0, 0,      1, 3, 0, 0, 'hA5A5, 'h0000);
        tbl[7]  = mk(0, 0, 0,      0, 5, 0, 0, 'hA5A5, 'h0000);
        tbl[8]  = mk(1, 9, 'h4242, 0, 9, 0, 0, 'hA5A5, 'h0000);
        tbl[9]  = mk(0, 0, 0,      0, 0, 0, 0, 'hA5A5, 'h0000);
        tbl[10] = mk(0, 0, 0,      1, 5, 1, 5, 'hBEEF, 'hBEEF);
        tbl[11] = mk(1, 0, 'h1111, 1, 0, 1, 3, 'h0000, 'hA5A5);

        model_reset();
        #2;
        check("reset rdata1", 32'(rdata1), 0);
        check("reset rdata2", 32'(rdata2), 0);
        check("reset clr_busy", 32'(clr_busy), 0);
        check("reset clr_done", 32'(clr_done), 0);
        @(negedge clk);
        rst = 1;

        foreach (tbl[i]) begin
            wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            ren1 = tbl[i].ren1; raddr1 = tbl[i].raddr1;
            ren2 = tbl[i].ren2; raddr2 = tbl[i].raddr2;
            cycle();
            check($sformatf("vec%0d rdata1", i), 32'(rdata1), 32'(tbl[i].e1));
            check($sformatf("vec%0d rdata2", i), 32'(rdata2), 32'(tbl[i].e2));
        end
        idle_inputs();

        // Fill, then clear with a stray write and a repeated request inside.
        for (int a = 0; a < D; a++) begin
            wen = 1; waddr = AW'(a); wdata = W'(16'hA000 + a);
            cycle();
        end
        idle_inputs();
        clr_req = 1;
        cycle();
        clr_req = 0;
        busy_cnt = int'(clr_busy);
        done_cnt = 0;
        check_model("clr start");
        for (int k = 0; k < 24; k++) begin
            wen = (k == 3); waddr = 9; wdata = 16'hDEAD;
            clr_req = (k == 5);
            cycle();
            busy_cnt += int'(clr_busy);
            done_cnt += int'(clr_done);
            check_model("clr run");
        end
        idle_inputs();
        check("clr busy cycles", 32'(busy_cnt), 16);
        check("clr done pulses", 32'(done_cnt), 1);
        for (int a = 0; a < D; a++) begin
            ren1 = 1; raddr1 = AW'(a); ren2 = 1; raddr2 = AW'(D - 1 - a);
            cycle();
            check($sformatf("cleared p1 a%0d", a), 32'(rdata1), 0);
            check($sformatf("cleared p2 a%0d", D - 1 - a), 32'(rdata2), 0);
        end
        idle_inputs();

        // Write and clear request together: write lands, clear later zeroes it.
        wen = 1; waddr = 15; wdata = 16'h7777; clr_req = 1;
        cycle();
        idle_inputs();
        ren1 = 1; raddr1 = 15;
        cycle();
        check("wr+clr first read", 32'(rdata1), 32'h7777);
        ren1 = 0;
        for (int k = 0; k < 20; k++) cycle();
        ren1 = 1;
        cycle();
        check("wr+clr after clear", 32'(rdata1), 0);
        idle_inputs();

        // Reset in the middle of a clear.
        for (int a = 1; a < D; a++) begin
            wen = 1; waddr = AW'(a); wdata = W'(16'h5A00 + a);
            cycle();
        end
        idle_inputs();
        ren1 = 1; raddr1 = 12;
        cycle();
        ren1 = 0;
        clr_req = 1;
        cycle();
        clr_req = 0;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            done_cnt += int'(clr_done);
        end
        check("pre-abort busy", 32'(clr_busy), 1);
        check("pre-abort rdata1", 32'(rdata1), 32'h5A0C);
        #2 rst = 0;
        #1;
        check("abort busy", 32'(clr_busy), 0);
        check("abort rdata1", 32'(rdata1), 0);
        model_reset();
        @(negedge clk);
        rst = 1;
        for (int a = 0; a < D; a++) begin
            ren1 = 1; raddr1 = AW'(a); ren2 = 1; raddr2 = AW'(a);
            cycle();
            done_cnt += int'(clr_done);
            check($sformatf("abort read a%0d", a), 32'(rdata1), 0);
            check_model("abort read");
        end
        check("abort no done", 32'(done_cnt), 0);
        idle_inputs();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wen = 1'($urandom); waddr = AW'($urandom); wdata = W'($urandom);
            ren1 = 1'($urandom); raddr1 = AW'($urandom);
            ren2 = 1'($urandom); raddr2 = AW'($urandom);
            if ($urandom_range(3) == 0) raddr2 = raddr1;
            if ($urandom_range(3) == 0) raddr1 = waddr;
            clr_req = ($urandom_range(59) == 0);
            cycle();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W entries.
REQ-002 Parameter WIDTH, default 16, data bits per entry.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 reads as zero and ignores writes.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wen  input  1  write enable.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 ren1 / ren2  input  1  read enable, port 1 / port 2.
REQ-010 raddr1 / raddr2  input  ADDR_W  read address, port 1 / port 2.
REQ-011 rdata1 / rdata2  output  WIDTH  registered read data, port 1 / port 2.
REQ-012 clr_req  input  1  request to zero the whole array.
REQ-013 clr_busy  output  1  high while the clear sequence runs.
REQ-014 clr_done  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-015 Storage: DEPTH x WIDTH flops; no tri-state anywhere, each read port has a dedicated output bus.
REQ-016 Write: wen=1 in IDLE -> mem[waddr] <= wdata at the rising edge.
REQ-017 ZERO_REG=1: writes to address 0 are discarded, reads of address 0 return 0.
REQ-018 Read latency: exactly 1 cycle; renN=1 at edge k -> rdataN valid after edge k, held until the next edge with renN=1.
REQ-019 renN=0: rdataN holds its previous value.
REQ-020 Bypass: renN=1, wen=1, raddrN==waddr in IDLE -> rdataN <= wdata (write-before-read), except address 0 when ZERO_REG=1 -> 0.
REQ-021 Both ports may read the same address in the same cycle; each receives identical data.
REQ-022 FSM states: IDLE, CLEAR.
REQ-023 IDLE -> CLEAR when clr_req=1 at an edge; internal counter cnt <= 0.
REQ-024 CLEAR: each edge writes mem[cnt] <= 0 and increments cnt; cnt==DEPTH-1 -> IDLE; a clear takes exactly DEPTH cycles.
REQ-025 clr_busy=1 exactly while state==CLEAR.
REQ-026 clr_done=1 for one cycle, on the edge that returns the FSM to IDLE.
REQ-027 While CLEAR: wen ignored, no bypass; reads return current array contents (cleared or not yet cleared).
REQ-028 clr_req while CLEAR: ignored; no restart, no extension.
REQ-029 clr_req and wen in the same IDLE cycle: the write completes at that edge, then the clear starts (the entry is later zeroed).
REQ-030 cnt width: ADDR_W bits; no wrap past DEPTH-1, because the FSM exits first.

Reset
REQ-031 rst=0 asynchronously: all entries 0, rdata1=rdata2=0, state IDLE, cnt 0, clr_busy=0, clr_done=0.
REQ-032 Reset asserted mid-CLEAR aborts the sequence; after release, state IDLE and every entry reads 0.
REQ-033 The first edge after rst deasserts operates normally with no dead cycle.

Verification
REQ-034 Write 0xBEEF to addr 5; next cycle ren1=1 raddr1=5 -> rdata1=0xBEEF one edge later.
REQ-035 wen=1 waddr=7 wdata=0x1234 with ren2=1 raddr2=7 in the same cycle -> rdata2=0x1234 after that edge (bypass).
REQ-036 ZERO_REG=1: write 0xFFFF to addr 0, then read addr 0 on both ports -> rdata1=rdata2=0x0000.
REQ-037 Fill all 16 entries with non-zero data, pulse clr_req -> clr_busy high for 16 cycles, clr_done pulses once, all reads then return 0; a wen pulse during clear has no effect.
REQ-038 Assert rst=0 at cycle 6 of a clear -> clr_busy=0 immediately; after release, all entries read 0 and clr_done never pulsed.
REQ-039 ren1=0 for 3 cycles after reading 0xA5A5 while addr changes -> rdata1 stays 0xA5A5.
